// File: rtl/cordic_const_seq_pkg.sv
// Shared encodings and ROM initialisation helpers for the CORDIC constant
// sequencer: FSM states, mode values, repeat indices and IEEE-754 builders.
package cordic_const_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    typedef enum logic {
        MODE_CIRC = 1'b0,
        MODE_HYP  = 1'b1
    } mode_e;

    localparam int REP_K0 = 4;
    localparam int REP_K1 = 13;
    localparam int REP_K2 = 40;

    localparam int  SERIES_N = 32;
    localparam real PI_4     = 0.78539816339744830962;

    function automatic logic is_rep_k(input int k);
        return (k == REP_K0) || (k == REP_K1) || (k == REP_K2);
    endfunction

    function automatic real pow2_neg(input int k);
        real x;
        x = 1.0;
        for (int i = 0; i < k; i++) begin
            x = x / 2.0;
        end
        return x;
    endfunction

    // Horner form keeps the sum near 1.0, so scaling by 2^-k stays exact.
    function automatic logic [63:0] atan_bits(input int k);
        real x;
        real x2;
        real s;
        if (k == 0) begin
            return $realtobits(PI_4);
        end
        x  = pow2_neg(k);
        x2 = x * x;
        s  = 1.0 / real'(2 * SERIES_N + 1);
        for (int n = SERIES_N - 1; n >= 0; n--) begin
            s = 1.0 / real'(2 * n + 1) - x2 * s;
        end
        return $realtobits(x * s);
    endfunction

    function automatic logic [63:0] atanh_bits(input int k);
        real x;
        real x2;
        real s;
        x  = pow2_neg(k);
        x2 = x * x;
        s  = 1.0 / real'(2 * SERIES_N + 1);
        for (int n = SERIES_N - 1; n >= 0; n--) begin
            s = 1.0 / real'(2 * n + 1) + x2 * s;
        end
        return $realtobits(x * s);
    endfunction

    // Binary64 -> binary32, round to nearest even; inputs are normal.
    function automatic logic [31:0] dbl_to_sgl(input logic [63:0] d);
        logic [10:0] e11;
        logic [31:0] r;
        logic        g;
        logic        st;
        if (d[62:0] == 63'd0) begin
            return {d[63], 31'd0};
        end
        e11 = d[62:52] - 11'd896;
        r   = {d[63], e11[7:0], d[51:29]};
        g   = d[28];
        st  = |d[27:0];
        if (g && (st || r[0])) begin
            r = r + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_const_rom.sv
// Dual CORDIC constant ROM: atan(2^-k) and atanh(2^-k) tables with a
// registered, enable-gated read port.
module cordic_const_rom
    import cordic_const_seq_pkg::*;
#(
    parameter int ROM_WIDTH = 32,
    parameter int ADDR_W    = 6
) (
    input  logic                 CLK,
    input  logic                 EN,
    input  logic                 MODE,
    input  logic [ADDR_W-1:0]    ADRS,
    output logic [ROM_WIDTH-1:0] O_D
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ROM_WIDTH-1:0] circ_t [DEPTH];
    logic [ROM_WIDTH-1:0] hyp_t  [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        localparam logic [63:0] CB = atan_bits(g);
        localparam logic [63:0] HB = (g == 0) ? 64'd0 : atanh_bits(g);
        localparam logic [63:0] CW =
            (ROM_WIDTH == 64) ? CB : {32'd0, dbl_to_sgl(CB)};
        localparam logic [63:0] HW =
            (ROM_WIDTH == 64) ? HB : {32'd0, dbl_to_sgl(HB)};
        assign circ_t[g] = CW[ROM_WIDTH-1:0];
        assign hyp_t[g]  = HW[ROM_WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (EN) begin
            O_D <= MODE ? hyp_t[ADRS] : circ_t[ADRS];
        end
    end

endmodule

// File: rtl/cordic_const_seq.sv
// CORDIC constant sequencer: streams one atan/atanh constant per cycle with
// shift amount, ordinal and VALID/LAST/DONE framing, honouring STALL.
module cordic_const_seq
    import cordic_const_seq_pkg::*;
#(
    parameter int ROM_WIDTH = 32,
    parameter int ADDR_W    = 6,
    parameter int N_ITER    = 24
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 MODE,
    input  logic                 STALL,
    output logic                 BUSY,
    output logic                 VALID,
    output logic                 LAST,
    output logic                 DONE,
    output logic [ADDR_W:0]      ITER_IDX,
    output logic [ADDR_W-1:0]    SHIFT,
    output logic [ROM_WIDTH-1:0] O_D
);

    localparam logic [ADDR_W-1:0] K_END_HYP  = ADDR_W'(N_ITER);
    localparam logic [ADDR_W-1:0] K_END_CIRC = ADDR_W'(N_ITER - 1);

    state_e              state_q;
    mode_e               mode_q;
    logic [ADDR_W-1:0]   k_q;
    logic                rep_q;
    logic [ADDR_W:0]     cnt_q;

    logic                a_vld_q;
    logic                a_last_q;
    logic [ADDR_W-1:0]   a_k_q;
    logic [ADDR_W:0]     a_idx_q;

    logic                vld_q;
    logic                last_q;
    logic [ADDR_W-1:0]   shift_q;
    logic [ADDR_W:0]     idx_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W-1:0]   k_d;
    logic                rep_d;
    logic                fin_d;
    logic                hold_k;
    logic [ROM_WIDTH-1:0] rom_q;

    always_comb begin
        hold_k = 1'b0;
        fin_d  = 1'b0;
        if (mode_q == MODE_HYP) begin
            hold_k = is_rep_k(int'(k_q)) && !rep_q;
            fin_d  = (k_q == K_END_HYP) && !hold_k;
        end else begin
            fin_d  = (k_q == K_END_CIRC);
        end
        k_d   = hold_k ? k_q : k_q + 1'b1;
        rep_d = hold_k;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_CIRC;
            k_q      <= '0;
            rep_q    <= 1'b0;
            cnt_q    <= '0;
            a_vld_q  <= 1'b0;
            a_last_q <= 1'b0;
            a_k_q    <= '0;
            a_idx_q  <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            shift_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (!STALL) begin
            vld_q   <= a_vld_q;
            last_q  <= a_last_q;
            shift_q <= a_k_q;
            idx_q   <= a_idx_q;
            a_vld_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        mode_q  <= mode_e'(MODE);
                        k_q     <= MODE ? ADDR_W'(1) : '0;
                        rep_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_vld_q  <= 1'b1;
                    a_last_q <= fin_d;
                    a_k_q    <= k_q;
                    a_idx_q  <= cnt_q;
                    cnt_q    <= cnt_q + 1'b1;
                    k_q      <= k_d;
                    rep_q    <= rep_d;
                    if (fin_d) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (vld_q && last_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    cordic_const_rom #(
        .ROM_WIDTH(ROM_WIDTH),
        .ADDR_W   (ADDR_W)
    ) u_rom (
        .CLK (CLK),
        .EN  (~STALL),
        .MODE(mode_q == MODE_HYP),
        .ADRS(a_k_q),
        .O_D (rom_q)
    );

    // The ROM register has no reset; qualifying by VALID keeps O_D at 0.
    assign O_D      = vld_q ? rom_q : '0;
    assign BUSY     = busy_q;
    assign VALID    = vld_q;
    assign LAST     = last_q;
    assign DONE     = done_q;
    assign ITER_IDX = idx_q;
    assign SHIFT    = shift_q;

endmodule

// File: tb/tb_cordic_const_seq.sv
// Directed bench for cordic_const_seq: framing, shift sequences, constants,
// stall hold, START filtering, mid-run reset and a short hyperbolic run.
module tb_cordic_const_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start4 = 1'b0;
    logic mode = 1'b0;
    logic stall = 1'b0;

    logic        busy, valid, last, done;
    logic [6:0]  idx;
    logic [5:0]  sh;
    logic [31:0] od;

    logic        busy4, valid4, last4, done4;
    logic [6:0]  idx4;
    logic [5:0]  sh4;
    logic [31:0] od4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] g_od   [64];
    logic [5:0]  g_sh   [64];
    logic [6:0]  g_idx  [64];
    logic        g_last [64];

    typedef struct {
        logic        m;
        int          w;
        logic [5:0]  sh;
        logic [31:0] od;
    } vec_t;

    vec_t vt [10];

    always #5 clk = ~clk;

    cordic_const_seq #(.ROM_WIDTH(32), .ADDR_W(6), .N_ITER(24)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode),
        .STALL(stall), .BUSY(busy), .VALID(valid), .LAST(last),
        .DONE(done), .ITER_IDX(idx), .SHIFT(sh), .O_D(od)
    );

    cordic_const_seq #(.ROM_WIDTH(32), .ADDR_W(6), .N_ITER(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .START(start4), .MODE(mode),
        .STALL(stall), .BUSY(busy4), .VALID(valid4), .LAST(last4),
        .DONE(done4), .ITER_IDX(idx4), .SHIFT(sh4), .O_D(od4)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_seq(input logic m, input int stall_w,
                           input bit hold_start, input int exp_n);
        logic [5:0]  esh [64];
        logic [31:0] hod;
        int ne, kk, rr, nw, c, first_c, dones;
        bit stalled, fin;
        kk = m ? 1 : 0;
        rr = 0;
        ne = 0;
        while (ne < 64) begin
            esh[ne] = 6'(kk);
            ne++;
            if (m) begin
                if ((kk == 4 || kk == 13 || kk == 40) && rr == 0) begin
                    rr = 1;
                end else begin
                    if (kk == 24) break;
                    kk++;
                    rr = 0;
                end
            end else begin
                if (kk == 23) break;
                kk++;
            end
        end
        nw = 0; c = 0; first_c = -1; dones = 0;
        stalled = 1'b0; fin = 1'b0;
        @(negedge clk);
        mode = m;
        start = 1'b1;
        while (!fin && c < 300) begin
            @(negedge clk);
            c++;
            if (!hold_start) start = 1'b0;
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            if (valid) begin
                if (first_c < 0) first_c = c;
                if (!stalled && int'(idx) == stall_w) begin
                    hod = od;
                    stall = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        c++;
                        chk("stall_od", 64'(od), 64'(hod));
                        chk("stall_idx", 64'(idx), 64'(stall_w));
                        chk("stall_shift", 64'(sh), 64'(esh[stall_w]));
                        chk("stall_valid", 64'(valid), 64'd1);
                    end
                    stall = 1'b0;
                    stalled = 1'b1;
                end
                if (nw < 64) begin
                    g_od[nw]   = od;
                    g_sh[nw]   = sh;
                    g_idx[nw]  = idx;
                    g_last[nw] = last;
                end
                nw++;
            end
        end
        chk("done_seen", 64'(fin), 64'd1);
        chk("first_valid_cycle", 64'(first_c), 64'd3);
        chk("word_count", 64'(nw), 64'(exp_n));
        for (int i = 0; i < nw && i < 64 && i < ne; i++) begin
            chk($sformatf("shift[%0d]", i), 64'(g_sh[i]), 64'(esh[i]));
            chk($sformatf("idx[%0d]", i), 64'(g_idx[i]), 64'(i));
            chk($sformatf("last[%0d]", i), 64'(g_last[i]),
                64'(i == exp_n - 1));
        end
        for (int j = 0; j < 10; j++) begin
            if (vt[j].m == m && vt[j].w < nw) begin
                chk($sformatf("od_w%0d", vt[j].w),
                    64'(g_od[vt[j].w]), 64'(vt[j].od));
                chk($sformatf("tab_sh_w%0d", vt[j].w),
                    64'(g_sh[vt[j].w]), 64'(vt[j].sh));
            end
        end
        @(negedge clk);
        chk("busy_after_fin", 64'(busy), 64'd0);
        chk("done_width", 64'(done), 64'd0);
        if (hold_start) begin
            @(negedge clk);
            chk("restart_in_idle", 64'(busy), 64'd1);
            start = 1'b0;
            do_reset();
        end else begin
            repeat (3) begin
                @(negedge clk);
                if (done) dones++;
            end
            chk("done_pulses", 64'(dones), 64'd1);
        end
    endtask

    initial begin
        logic [5:0] e4 [5];
        int c, d, n4;
        vt[0] = '{1'b0, 0,  6'd0,  32'h3F490FDB};
        vt[1] = '{1'b0, 1,  6'd1,  32'h3EED6338};
        vt[2] = '{1'b0, 11, 6'd11, 32'h39FFFFFF};
        vt[3] = '{1'b0, 12, 6'd12, 32'h39800000};
        vt[4] = '{1'b0, 23, 6'd23, 32'h34000000};
        vt[5] = '{1'b1, 0,  6'd1,  32'h3F0C9F54};
        vt[6] = '{1'b1, 1,  6'd2,  32'h3E82C578};
        vt[7] = '{1'b1, 11, 6'd11, 32'h3A000001};
        vt[8] = '{1'b1, 14, 6'd13, 32'h39000000};
        vt[9] = '{1'b1, 25, 6'd24, 32'h33800000};
        e4 = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd4};

        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_last", 64'(last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_shift", 64'(sh), 64'd0);
        chk("rst_od", 64'(od), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(1'b0, -1, 1'b0, 24);
        run_seq(1'b1, 5, 1'b0, 26);
        run_seq(1'b1, -1, 1'b1, 26);

        @(negedge clk);
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!(valid && idx == 7'd10) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("mid_run_reached", 64'(c < 100), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_valid", 64'(valid), 64'd0);
        chk("async_last", 64'(last), 64'd0);
        chk("async_idx", 64'(idx), 64'd0);
        chk("async_shift", 64'(sh), 64'd0);
        chk("async_od", 64'(od), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) d++;
        end
        chk("no_done_after_rst", 64'(d), 64'd0);
        chk("idle_after_rst", 64'(busy), 64'd0);
        run_seq(1'b1, -1, 1'b0, 26);

        @(negedge clk);
        mode = 1'b1;
        start4 = 1'b1;
        n4 = 0;
        c = 0;
        while (!done4 && c < 50) begin
            @(negedge clk);
            c++;
            start4 = 1'b0;
            if (valid4) begin
                if (n4 < 5) begin
                    chk($sformatf("n4_shift[%0d]", n4), 64'(sh4),
                        64'(e4[n4]));
                    chk($sformatf("n4_idx[%0d]", n4), 64'(idx4), 64'(n4));
                end
                chk($sformatf("n4_last[%0d]", n4), 64'(last4),
                    64'(n4 == 4));
                n4++;
            end
        end
        chk("n4_done_seen", 64'(done4), 64'd1);
        chk("n4_count", 64'(n4), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
